// File: rtl/mux_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mux_arbiter_pkg                                                      |
// | State encoding and defaults shared by the mux arbiter and datapath.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package mux_arbiter_pkg;
    localparam int c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_IDLE = 2'd0;
    localparam logic [c_STATE_W-1:0] c_G1   = 2'd1;
    localparam logic [c_STATE_W-1:0] c_G2   = 2'd2;

    localparam int c_MAX_HOLD_DEF = 8;
endpackage

`default_nettype wire

// File: rtl/mux_arbiter_dp.sv
// +----------------------------------------------------------------------+
// | mux_arbiter_dp                                                       |
// | Registered 2:1 mux output word with valid flag, loaded while granted.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module mux_arbiter_dp #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_gnt,
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    output logic [WIDTH-1:0] o_out,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_out;
    logic             r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_gnt;
            if (i_gnt) begin
                r_out <= i_sel ? i_in2 : i_in1;
            end
        end
    end

    assign o_out   = r_out;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/mux_arbiter.sv
// +----------------------------------------------------------------------+
// | mux_arbiter                                                          |
// | Round-robin two-requester arbiter owning the shared mux select.      |
// | Option: MUX_ARBITER_TIMEOUT_EN bounds a contested grant to MAX_HOLD. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = c_MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req1,
    input  logic             req2,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             gnt1,
    output logic             gnt2,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             valid
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next;
    logic                 r_last;   // 0: requester 1 granted last, 1: requester 2
    logic                 r_sel;
    logic                 w_hold_max;

`ifdef MUX_ARBITER_TIMEOUT_EN
    localparam int                    c_HOLD_W    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0]   c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);

    logic [c_HOLD_W-1:0] r_hold;

    // Saturates at the limit so an uncontested grant simply continues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (r_state == c_IDLE) begin
            r_hold <= '0;
        end else if (!w_hold_max) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    assign w_hold_max = (r_hold == c_HOLD_LAST);
`else
    assign w_hold_max = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == c_IDLE && w_next == c_G1) begin
                r_last <= 1'b0;
                r_sel  <= 1'b0;
            end else if (r_state == c_IDLE && w_next == c_G2) begin
                r_last <= 1'b1;
                r_sel  <= 1'b1;
            end
        end
    end

    // Grants only ever return to IDLE, guaranteeing a gap on every handover.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (req1 && req2) begin
                    w_next = r_last ? c_G1 : c_G2;
                end else if (req1) begin
                    w_next = c_G1;
                end else if (req2) begin
                    w_next = c_G2;
                end
            end
            c_G1: begin
                if (!req1 || (w_hold_max && req2)) begin
                    w_next = c_IDLE;
                end
            end
            c_G2: begin
                if (!req2 || (w_hold_max && req1)) begin
                    w_next = c_IDLE;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        gnt1 = (r_state == c_G1);
        gnt2 = (r_state == c_G2);
        sel  = r_sel;
    end

    mux_arbiter_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_gnt   (gnt1 | gnt2),
        .i_sel   (r_sel),
        .i_in1   (in1),
        .i_in2   (in2),
        .o_out   (out),
        .o_valid (valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_mux_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mux_arbiter                                                       |
// | Directed self-checking bench for mux_arbiter (WIDTH=8, MAX_HOLD=4).  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req1;
    logic       req2;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       gnt1;
    logic       gnt2;
    logic       sel;
    logic [7:0] out;
    logic       valid;

    int n_cmp = 0;
    int n_err = 0;

    mux_arbiter #(
        .WIDTH    (8),
        .MAX_HOLD (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req1  (req1),
        .req2  (req2),
        .in1   (in1),
        .in2   (in2),
        .gnt1  (gnt1),
        .gnt2  (gnt2),
        .sel   (sel),
        .out   (out),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs {gnt1, gnt2, sel, valid, out} for a single compact comparison.
    function automatic logic [31:0] st();
        return {20'd0, gnt1, gnt2, sel, valid, out};
    endfunction

    function automatic logic [31:0] ex(input logic g1, g2, s, v, input logic [7:0] o);
        return {20'd0, g1, g2, s, v, o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req1  = 1'b0;
        req2  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        req1  = 1'b0;
        req2  = 1'b0;
        in1   = 8'hA5;
        in2   = 8'h3C;
        step();
        check("reset_held", st(), ex(0, 0, 0, 0, 8'h00));
        rst_n = 1'b1;
        step();
        check("reset_idle", st(), ex(0, 0, 0, 0, 8'h00));

        // Single request: grant after one edge, data after two.
        req1 = 1'b1;
        step();
        check("r1_grant", st(), ex(1, 0, 0, 0, 8'h00));
        step();
        check("r1_data", st(), ex(1, 0, 0, 1, 8'hA5));
        req1 = 1'b0;
        step();
        check("r1_gnt_fall", st(), ex(0, 0, 0, 1, 8'hA5));
        step();
        check("r1_valid_fall", st(), ex(0, 0, 0, 0, 8'hA5));

        // Simultaneous requests after reset: requester 1 first.
        do_reset();
        req1 = 1'b1;
        req2 = 1'b1;
        step();
        check("tie_first_g1", st(), ex(1, 0, 0, 0, 8'h00));
        step();
        check("tie_g1_data", st(), ex(1, 0, 0, 1, 8'hA5));
        req1 = 1'b0;
        step();
        check("handover_idle", st(), ex(0, 0, 0, 1, 8'hA5));
        step();
        check("handover_g2", st(), ex(0, 1, 1, 0, 8'hA5));
        step();
        check("g2_data", st(), ex(0, 1, 1, 1, 8'h3C));

        // Tie after a G2 release goes to requester 1.
        req2 = 1'b0;
        step();
        check("g2_release", st(), ex(0, 0, 1, 1, 8'h3C));
        req1 = 1'b1;
        req2 = 1'b1;
        step();
        check("rr_after_g2", st(), ex(1, 0, 0, 0, 8'h3C));

        // Tie after a G1 release goes to requester 2.
        req1 = 1'b0;
        req2 = 1'b0;
        step();
        check("g1_release", st(), ex(0, 0, 0, 1, 8'hA5));
        req1 = 1'b1;
        req2 = 1'b1;
        step();
        check("rr_after_g1", st(), ex(0, 1, 1, 0, 8'hA5));
        step();
        check("g2_valid", st(), ex(0, 1, 1, 1, 8'h3C));

        // Asynchronous reset mid-grant clears outputs before any edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", st(), ex(0, 0, 0, 0, 8'h00));
        #3;
        rst_n = 1'b1;
        step();
        check("post_reset_r1", st(), ex(1, 0, 0, 0, 8'h00));

`ifdef MUX_ARBITER_TIMEOUT_EN
        // Contested grant is cut after MAX_HOLD cycles.
        do_reset();
        req1 = 1'b1;
        step();
        check("to_g1", {31'd0, gnt1}, 32'd1);
        req2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("to_g1_hold", {30'd0, gnt1, gnt2}, 32'd2);
        end
        step();
        check("to_cut_idle", {30'd0, gnt1, gnt2}, 32'd0);
        step();
        check("to_g2", {29'd0, gnt1, gnt2, sel}, 32'd3);

        // Uncontested grant is never cut.
        do_reset();
        req1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("to_solo_hold", {30'd0, gnt1, gnt2}, 32'd2);
        end
`else
        // Without timeout a contested grant lasts until the owner releases.
        do_reset();
        req1 = 1'b1;
        req2 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            check("hold50", {30'd0, gnt1, gnt2}, 32'd2);
        end
        req1 = 1'b0;
        step();
        check("hold50_idle", {30'd0, gnt1, gnt2}, 32'd0);
        step();
        check("hold50_g2", {29'd0, gnt1, gnt2, sel}, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule

`default_nettype wire
